// File: rtl/vdp_super_res_writer.sv
// vdp_super_res_writer: CPU byte-pixel writer feeding 32-bit VRAM word writes via a FIFO.
// Optional SUPER_RES_WRITE_COALESCE_EN merges same-word pixel writes into the FIFO tail.
module vdp_super_res_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdp_super,
    input  logic        super_res_drawing,
    input  logic        cpu_addr_we,
    input  logic [1:0]  cpu_addr_sel,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_data_we,
    output logic        cpu_busy,
    output logic        overflow,
    output logic [18:0] write_ptr,
    output logic        vram_req,
    output logic [16:0] vram_addr,
    output logic [31:0] vram_wdata,
    output logic [3:0]  vram_be,
    input  logic        vram_ack
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [16:0]   fa_q [FIFO_DEPTH];
    logic [16:0]   fa_d [FIFO_DEPTH];
    logic [31:0]   fd_q [FIFO_DEPTH];
    logic [31:0]   fd_d [FIFO_DEPTH];
    logic [3:0]    fb_q [FIFO_DEPTH];
    logic [3:0]    fb_d [FIFO_DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [18:0]   ptr_q, ptr_d;
    logic          ovf_q, ovf_d;
    logic [16:0]   oaddr_q, oaddr_d;
    logic [31:0]   odata_q, odata_d;
    logic [3:0]    obe_q, obe_d;

    logic          full, empty, launch, pop;
    logic          merge, push, accept;
    logic [AW-1:0] tail_idx;
    logic [1:0]    lane;
    logic [16:0]   word;
    logic [3:0]    pix_be;
    logic [31:0]   pix_data, lane_mask;

    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign lane      = ptr_q[1:0];
    assign word      = ptr_q[18:2];
    assign pix_be    = 4'b0001 << lane;
    assign pix_data  = {24'd0, cpu_data} << {lane, 3'b000};
    assign lane_mask = {{8{pix_be[3]}}, {8{pix_be[2]}},
                        {8{pix_be[1]}}, {8{pix_be[0]}}};
    assign tail_idx  = wr_q - AW'(1);
    assign launch    = (state_q == S_IDLE) && !empty && !super_res_drawing;
    assign pop       = (state_q == S_REQ) && vram_ack;

`ifdef SUPER_RES_WRITE_COALESCE_EN
    // The entry on (or being put on) the bus is frozen: merging would lose bytes at pop.
    assign merge = cpu_data_we && !empty && (fa_q[tail_idx] == word)
                   && !(((state_q == S_REQ) || launch) && (cnt_q == ONE_CNT));
`else
    assign merge = 1'b0;
`endif
    assign push   = cpu_data_we && !merge && !full;
    assign accept = merge || push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fa_q[i] <= '0;
                fd_q[i] <= '0;
                fb_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
            obe_q   <= '0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            fd_q    <= fd_d;
            fb_q    <= fb_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            obe_q   <= obe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (launch) state_d = S_REQ;
            S_REQ:  if (vram_ack) state_d = S_IDLE;
        endcase
        if (!vdp_super) state_d = S_IDLE;
    end

    always_comb begin
        fa_d  = fa_q;
        fd_d  = fd_q;
        fb_d  = fb_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (merge) begin
            fd_d[tail_idx] = (fd_q[tail_idx] & ~lane_mask) | pix_data;
            fb_d[tail_idx] = fb_q[tail_idx] | pix_be;
        end
        if (push) begin
            fa_d[wr_q] = word;
            fd_d[wr_q] = pix_data;
            fb_d[wr_q] = pix_be;
            wr_d       = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        if (!vdp_super) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fa_d[i] = '0;
                fd_d[i] = '0;
                fb_d[i] = '0;
            end
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Pointer loads are applied after the increment so the loaded field wins.
    always_comb begin
        ptr_d = ptr_q;
        ovf_d = ovf_q;
        if (accept) ptr_d = ptr_q + 19'd1;
        if (cpu_data_we && !accept) ovf_d = 1'b1;
        if (cpu_addr_we) begin
            unique case (cpu_addr_sel)
                2'd0: begin
                    ptr_d[7:0] = cpu_data;
                    ovf_d      = 1'b0;
                end
                2'd1: begin
                    ptr_d[15:8] = cpu_data;
                    ovf_d       = 1'b0;
                end
                2'd2: begin
                    ptr_d[18:16] = cpu_data[2:0];
                    ovf_d        = 1'b0;
                end
                2'd3: ;
            endcase
        end
        if (!vdp_super) begin
            ptr_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        obe_d   = obe_q;
        if (launch) begin
            oaddr_d = fa_q[rd_q];
            odata_d = fd_q[rd_q];
            obe_d   = fb_q[rd_q];
        end
        if (!vdp_super) begin
            oaddr_d = '0;
            odata_d = '0;
            obe_d   = '0;
        end
    end

    always_comb begin
        vram_req   = (state_q == S_REQ);
        vram_addr  = oaddr_q;
        vram_wdata = odata_q;
        vram_be    = obe_q;
        cpu_busy   = full;
        overflow   = ovf_q;
        write_ptr  = ptr_q;
    end

endmodule

// File: doc/vdp_super_res_writer.md
# vdp_super_res_writer

CPU-side pixel writer for the super-res/super-mid framebuffer: the write-side counterpart of the super-res display fetch. It takes byte-wide pixel writes from the CPU port through an auto-incrementing 19-bit byte pointer, queues them in a 4-entry FIFO, and issues 32-bit VRAM writes with byte enables. Writes are launched only while the display fetch does not own the bus (`super_res_drawing` low).

## Interface
- `FIFO_DEPTH`, 4: queue entries; power of two, minimum 2.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vdp_super` in 1: super mode enable; 0 acts as a synchronous clear of FIFO, pointer and flags.
- `super_res_drawing` in 1: 1 = display fetch owns the VRAM bus, so no new request may be launched.
- `cpu_addr_we` in 1: load one pointer byte.
- `cpu_addr_sel` in 2: 0 = ptr[7:0], 1 = ptr[15:8], 2 = ptr[18:16] (`cpu_data[2:0]`), 3 = ignored.
- `cpu_data` in 8: pointer byte or pixel palette index.
- `cpu_data_we` in 1: pixel write at current pointer, then pointer +1.
- `cpu_busy` out 1: FIFO full.
- `overflow` out 1: sticky; a pixel write was dropped.
- `write_ptr` out 19: current byte pointer.
- `vram_req` out 1: write request.
- `vram_addr` out 17: word address = byte address[18:2].
- `vram_wdata` out 32: pixel bytes in their lanes; unused lanes 0.
- `vram_be` out 4: byte enables; bit n covers `vram_wdata[8n+7:8n]`.
- `vram_ack` in 1: one-cycle accept of the current request.

## Operation
- Reset (`reset_n` = 0) or `vdp_super` = 0 clears the following outputs and state to 0: `write_ptr`, FIFO, `overflow`, `vram_req`, `vram_addr`, `vram_wdata`, `vram_be`, `cpu_busy`.
  - A request that is pending at this point is abandoned. `vram_req` drops the next cycle, or immediately on async reset.
- Each FIFO entry holds a 17-bit word address, 32-bit data and 4-bit byte enables.
- Pixel write (`cpu_data_we` with FIFO not full at cycle start):
  - Enqueue word = ptr[18:2], lane = ptr[1:0], be = one-hot(lane), data = `cpu_data` in that lane.
  - The pointer increments mod 2^19, so 0x7FFFF wraps to 0x00000.
- Pixel write while full: dropped, the pointer is not incremented, and `overflow` is set.
- Pointer byte write: updates the selected field and clears `overflow`.
- Simultaneous `cpu_addr_we` and `cpu_data_we`:
  - The pixel uses the pre-cycle pointer.
  - The loaded byte wins on its field; the other fields take the incremented value.
- Simultaneous pop (ack) and push on a full FIFO: the push is still dropped, because fullness is judged at cycle start.
- Drain state machine:
  - IDLE: if FIFO not empty and `super_res_drawing` = 0, then register head onto `vram_addr`/`vram_wdata`/`vram_be`, set `vram_req`, and go to REQ.
  - REQ: hold all `vram_*` outputs stable. On `vram_ack`, pop head, drop `vram_req`, and go to IDLE.
  - `super_res_drawing` rising while in REQ does not withdraw the request.

## Timing
- A write accepted at cycle t is in the FIFO at t+1. Earliest `vram_req` is at t+2, if `super_res_drawing` was low at t+1.
- `vram_ack` is sampled only while `vram_req` = 1. An ack seen in the first REQ cycle is legal.
- `vram_req` is low for at least one cycle between requests. Back-to-back throughput is therefore one write per 2 cycles at best.
- `cpu_busy` and `write_ptr` are registered and reflect state at the cycle start.

## Configuration
- `SUPER_RES_WRITE_COALESCE_EN` defined:
  - A pixel write whose word address equals the FIFO tail entry's merges into that entry. It ORs its enable bit, replaces its lane byte, and does not consume a slot.
  - It does not merge if the tail is the head currently in REQ.
  - Because a merge does not consume a slot, a merge into a tail is accepted even when the FIFO is full.
- Undefined: every pixel write is its own entry with a one-hot `vram_be`.

## Test plan
- Reset and enable:
  - Hold `reset_n` low with `vdp_super` = 1: all outputs are 0.
  - Release, load ptr = 0x00005, write 0xAA: one request with `vram_addr` = 1, `vram_be` = 4'b0010, `vram_wdata` = 0x0000AA00; `write_ptr` = 0x00006.
- Arbitration:
  - Hold `super_res_drawing` = 1 and write 3 pixels: no `vram_req`.
  - Drop `super_res_drawing`: 3 requests issue in order. Raising `super_res_drawing` mid-REQ keeps the current request until ack.
- Overflow:
  - Hold `super_res_drawing` = 1 and write 5 pixels: `cpu_busy` = 1 after the 4th; the 5th is dropped and `overflow` = 1; `write_ptr` has advanced by 4.
  - A pointer byte write clears `overflow`.
- Wrap and simultaneity:
  - ptr = 0x7FFFF, write 0x11: `vram_addr` = 0x1FFFF, `vram_be` = 4'b1000; `write_ptr` = 0.
  - Same-cycle `cpu_addr_we`(sel 0, 0x40) with `cpu_data_we`: the pixel goes to the old pointer; `write_ptr`[7:0] = 0x40.
- Coalescing (macro on):
  - With `super_res_drawing` = 1, write 4 pixels from ptr 0x100: one request with `vram_addr` = 0x40, `vram_be` = 4'hF, `vram_wdata` = {b3,b2,b1,b0}.
  - With the macro off: four requests.
- Disable mid-operation:
  - Drop `vdp_super` while in REQ with 3 entries queued: `vram_req` is 0 the next cycle, FIFO is empty, and `write_ptr` = 0.
